// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register-file slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK,
        IGNORE,
        WAIT
    } i2c_state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Synchronizer plus stability filter for one open-drain bus line, with
// single-cycle rise/fall pulses on the accepted level.
module i2c_in_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT < 2) ? 1 : $clog2(FILT);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          accept;

    // cnt counts consecutive synchronized samples that disagree with level
    assign accept = (sync_p1 != level) && (cnt == CW'(FILT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_p1;
                cnt   <= '0;
                rise  <= sync_p1;
                fall  <= ~sync_p1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing byte register file; oversamples
// SCL/SDA on PCLK and never stretches the clock.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NREG       = 16,
    parameter int         FILT       = 3
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    SCL_IN,
    input  logic                    SDA_IN,
    output logic                    SDA_OE,
    output logic                    REG_WE,
    output logic [$clog2(NREG)-1:0] REG_ADDR,
    output logic [7:0]              REG_WDATA,
    output logic                    BUSY
);

    localparam int AW = $clog2(NREG);

    logic          scl_lvl, scl_rise, scl_fall;
    logic          sda_lvl, sda_rise, sda_fall;
    logic          start_det, stop_det;
    i2c_state_e    state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [AW-1:0] ptr;
    logic          ptr_done;
    logic          rw;
    logic          ack_bit;
    logic          mst_ack;
    logic          oe_nxt;
    logic [7:0]    regs [NREG];
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic          byte_done;
    logic          ack_end;

    i2c_in_filter #(.FILT(FILT)) u_scl_filt (
        .clk(PCLK), .rst_n(PRESETn), .din(SCL_IN),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_in_filter #(.FILT(FILT)) u_sda_filt (
        .clk(PCLK), .rst_n(PRESETn), .din(SDA_IN),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall && scl_lvl;
    assign stop_det  = sda_rise && scl_lvl;
    assign rx_byte   = {shreg[6:0], sda_lvl};
    assign rd_byte   = regs[ptr];
    assign byte_done = scl_rise && (bit_cnt == 3'd7);
    // ack_bit marks that the ACK slot's rising edge has passed, so the next fall ends it
    assign ack_end   = scl_fall && ack_bit;

    always_comb begin
        state_nxt = state;
        oe_nxt    = SDA_OE;
        if (start_det) begin
            state_nxt = ADDR;
            oe_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR:     if (byte_done) state_nxt = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (ack_end)   state_nxt = (rw == I2C_RW_READ) ? READ : (ptr_done ? WRITE : PTR);
                PTR:      if (byte_done) state_nxt = PTR_ACK;
                PTR_ACK:  if (ack_end)   state_nxt = WRITE;
                WRITE:    if (byte_done) state_nxt = WR_ACK;
                WR_ACK:   if (ack_end)   state_nxt = WRITE;
                READ:     if (byte_done) state_nxt = RD_ACK;
                RD_ACK:   if (ack_end)   state_nxt = (mst_ack == I2C_ACK) ? READ : WAIT;
                default:  ;
            endcase
            if (scl_fall) begin
                case (state)
                    ADDR_ACK: oe_nxt = !ack_bit ? 1'b1 : ((rw == I2C_RW_READ) ? ~rd_byte[7] : 1'b0);
                    PTR_ACK,
                    WR_ACK:   oe_nxt = ~ack_bit;
                    READ:     oe_nxt = ~shreg[6];
                    RD_ACK:   oe_nxt = (ack_bit && mst_ack == I2C_ACK) ? ~rd_byte[7] : 1'b0;
                    default:  oe_nxt = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            SDA_OE    <= 1'b0;
            REG_WE    <= 1'b0;
            REG_ADDR  <= '0;
            REG_WDATA <= '0;
            BUSY      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            ptr_done  <= 1'b0;
            rw        <= 1'b0;
            ack_bit   <= 1'b0;
            mst_ack   <= 1'b1;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state  <= state_nxt;
            SDA_OE <= oe_nxt;
            REG_WE <= 1'b0;
            if (start_det) begin
                bit_cnt  <= '0;
                ptr_done <= 1'b0;
                ack_bit  <= 1'b0;
            end else if (stop_det) begin
                bit_cnt <= '0;
                ack_bit <= 1'b0;
                BUSY    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WRITE: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    READ: if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                          else if (scl_fall) shreg <= {shreg[6:0], 1'b0};
                    ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK: if (scl_rise) begin
                        ack_bit <= 1'b1;
                        mst_ack <= sda_lvl;
                    end else if (ack_end) begin
                        ack_bit <= 1'b0;
                    end
                    default: ;
                endcase
                if (state == ADDR && byte_done && rx_byte[7:1] == SLAVE_ADDR) begin
                    BUSY <= 1'b1;
                    rw   <= rx_byte[0];
                end
                if (state == PTR && byte_done) begin
                    ptr      <= rx_byte[AW-1:0];
                    ptr_done <= 1'b1;
                end
                if (state == WRITE && byte_done) begin
                    regs[ptr] <= rx_byte;
                    REG_WE    <= 1'b1;
                    REG_ADDR  <= ptr;
                    REG_WDATA <= rx_byte;
                    ptr       <= ptr + AW'(1);
                end
                if (state == READ && byte_done) ptr <= ptr + AW'(1);
                if (ack_end && state_nxt == READ) shreg <= rd_byte;
            end
        end
    end

endmodule
